// File: rtl/core_pipe_exec_mdu_px.sv
// Iterative multiply/divide unit for the execute stage, XLEN 32 or 64.
// MDU_RESULT_FUSE_EN: keep the last full product so a repeated multiply completes without iterating.
module core_pipe_exec_mdu_px #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 4,
  parameter int DIV_UNROLL = 2
) (
  input  logic            g_clk,
  input  logic            g_reset,
  output logic            g_clk_req,
  input  logic            flush,
  input  logic            valid,
  input  logic            op_word,
  input  logic            op_mul,
  input  logic            op_mulh,
  input  logic            op_mulhu,
  input  logic            op_mulhsu,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_rem,
  input  logic            op_remu,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic [XLEN-1:0] rd
);
  // state | meaning
  // IDLE  | waiting for valid; op and extended operands latched on accept
  // PREP  | absolute values, result sign, early-out check, counter load
  // RUN   | shift-add or restoring-divide iterations
  // FIX   | apply result sign and select result
  // DONE  | ready pulse, rd valid
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  localparam int PW = 2 * XLEN;
  localparam logic [63:0] MIN32 = 64'hFFFF_FFFF_8000_0000;
  localparam logic [7:0] NM_W = 8'(32 / MUL_UNROLL);
  localparam logic [7:0] NM_X = 8'(XLEN / MUL_UNROLL);
  localparam logic [7:0] ND_W = 8'(32 / DIV_UNROLL);
  localparam logic [7:0] ND_X = 8'(XLEN / DIV_UNROLL);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [63:0] t;
    t = {{32{x[31]}}, x};
    return t[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
    logic [63:0] t;
    t = {32'b0, x};
    return t[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] fmt(input logic w32, input logic [XLEN-1:0] x);
    return w32 ? sext32(x[31:0]) : x;
  endfunction

  function automatic logic [XLEN-1:0] sel_mul(input logic [PW-1:0] p, input logic lo, input logic w32);
    if (lo) return fmt(w32, p[XLEN-1:0]);
    if (w32) return sext32(p[63:32]);
    return p[PW-1:XLEN];
  endfunction

  state_t          r_state;
  logic            r_ready;
  logic [XLEN-1:0] r_rd;
  logic            r_is_mul, r_lo, r_is_rem, r_w32, r_a_sgn, r_b_sgn, r_neg;
  logic [XLEN-1:0] r_a, r_b;
  logic [7:0]      r_cnt;
  logic [PW-1:0]   r_prod, r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo, r_dvs;

  logic            w_is_mul, w_is_div, w_w32_in, w_a_sgn_in, w_b_sgn_in;
  logic [XLEN-1:0] w_a_in, w_b_in;
  logic            w_a_neg, w_b_neg, w_b_zero, w_ovf;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_min, w_early, w_dq, w_dres;
  logic [PW-1:0]   w_prod_nx, w_mcand_nx, w_pfix;
  logic [XLEN-1:0] w_mplier_nx, w_quo_nx;
  logic [XLEN:0]   w_rem_nx;
  logic            w_fuse_hit;
  logic [XLEN-1:0] w_fuse_rd;

  assign w_is_mul   = op_mul | op_mulh | op_mulhu | op_mulhsu;
  assign w_is_div   = op_div | op_divu | op_rem | op_remu;
  assign w_w32_in   = (XLEN == 64) && op_word;
  // mul is treated as signed x signed: low bits are identical either way
  assign w_a_sgn_in = ~(op_mulhu | op_divu | op_remu);
  assign w_b_sgn_in = op_mul | op_mulh | op_div | op_rem;
  assign w_a_in     = !w_w32_in ? rs1 : (w_a_sgn_in ? sext32(rs1[31:0]) : zext32(rs1[31:0]));
  assign w_b_in     = !w_w32_in ? rs2 : (w_b_sgn_in ? sext32(rs2[31:0]) : zext32(rs2[31:0]));

  assign w_a_neg  = r_a_sgn & r_a[XLEN-1];
  assign w_b_neg  = r_b_sgn & r_b[XLEN-1];
  assign w_a_abs  = w_a_neg ? -r_a : r_a;
  assign w_b_abs  = w_b_neg ? -r_b : r_b;
  assign w_b_zero = (r_b == '0);
  assign w_min    = r_w32 ? MIN32[XLEN-1:0] : {1'b1, {(XLEN-1){1'b0}}};
  assign w_ovf    = r_a_sgn & (r_a == w_min) & (&r_b);
  assign w_early  = fmt(r_w32, r_is_rem ? (w_b_zero ? r_a : '0) : (w_b_zero ? '1 : r_a));

  always_comb begin
    w_prod_nx   = r_prod;
    w_mcand_nx  = r_mcand;
    w_mplier_nx = r_mplier;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      if (w_mplier_nx[0]) w_prod_nx = w_prod_nx + w_mcand_nx;
      w_mcand_nx  = w_mcand_nx << 1;
      w_mplier_nx = w_mplier_nx >> 1;
    end
  end

  // remainder is one bit wider so the shifted partial remainder never overflows
  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      w_rem_nx = {w_rem_nx[XLEN-1:0], w_quo_nx[XLEN-1]};
      w_quo_nx = {w_quo_nx[XLEN-2:0], 1'b0};
      if (w_rem_nx >= {1'b0, r_dvs}) begin
        w_rem_nx    = w_rem_nx - {1'b0, r_dvs};
        w_quo_nx[0] = 1'b1;
      end
    end
  end

  assign w_pfix = r_neg ? -r_prod : r_prod;
  assign w_dq   = r_is_rem ? r_rem[XLEN-1:0] : r_quo;
  assign w_dres = fmt(r_w32, r_neg ? -w_dq : w_dq);

`ifdef MDU_RESULT_FUSE_EN
  logic            r_f_valid, r_f_w32, r_f_a_sgn, r_f_b_sgn;
  logic [XLEN-1:0] r_f_a, r_f_b;
  logic [PW-1:0]   r_f_prod;
  assign w_fuse_hit = r_f_valid & w_is_mul & (w_w32_in == r_f_w32) & (w_a_sgn_in == r_f_a_sgn) &
                      (w_b_sgn_in == r_f_b_sgn) & (w_a_in == r_f_a) & (w_b_in == r_f_b);
  assign w_fuse_rd  = sel_mul(r_f_prod, op_mul, w_w32_in);
`else
  assign w_fuse_hit = 1'b0;
  assign w_fuse_rd  = '0;
`endif

  always_ff @(posedge g_clk) begin
    if (g_reset | flush) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_rd    <= '0;
`ifdef MDU_RESULT_FUSE_EN
      r_f_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (valid) begin
            r_is_mul <= w_is_mul;
            r_lo     <= op_mul;
            r_is_rem <= op_rem | op_remu;
            r_w32    <= w_w32_in;
            r_a_sgn  <= w_a_sgn_in;
            r_b_sgn  <= w_b_sgn_in;
            r_a      <= w_a_in;
            r_b      <= w_b_in;
            if (w_fuse_hit) begin
              r_rd    <= w_fuse_rd;
              r_ready <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= PREP;
            end
`ifdef MDU_RESULT_FUSE_EN
            if (w_is_div) r_f_valid <= 1'b0;
`endif
          end
        end
        PREP: begin
          if (!r_is_mul && (w_b_zero || w_ovf)) begin
            r_rd    <= w_early;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else begin
            r_prod   <= '0;
            r_mcand  <= PW'(w_a_abs);
            r_mplier <= w_b_abs;
            r_rem    <= '0;
            r_quo    <= r_w32 ? (w_a_abs << (XLEN - 32)) : w_a_abs;
            r_dvs    <= w_b_abs;
            r_neg    <= (r_is_mul || !r_is_rem) ? (w_a_neg ^ w_b_neg) : w_a_neg;
            r_cnt    <= r_is_mul ? (r_w32 ? NM_W : NM_X) : (r_w32 ? ND_W : ND_X);
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (r_is_mul) begin
            r_prod   <= w_prod_nx;
            r_mcand  <= w_mcand_nx;
            r_mplier <= w_mplier_nx;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
          end
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= FIX;
        end
        FIX: begin
          r_rd    <= r_is_mul ? sel_mul(w_pfix, r_lo, r_w32) : w_dres;
          r_ready <= 1'b1;
          r_state <= DONE;
`ifdef MDU_RESULT_FUSE_EN
          if (r_is_mul) begin
            r_f_valid <= 1'b1;
            r_f_w32   <= r_w32;
            r_f_a_sgn <= r_a_sgn;
            r_f_b_sgn <= r_b_sgn;
            r_f_a     <= r_a;
            r_f_b     <= r_b;
            r_f_prod  <= w_pfix;
          end
`endif
        end
        DONE: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign rd        = r_rd;
  assign g_clk_req = valid | flush | (r_state != IDLE);

endmodule

// File: tb/tb_core_pipe_exec_mdu_px.sv
// Scoreboard bench for core_pipe_exec_mdu_px (XLEN=64, MUL_UNROLL=4, DIV_UNROLL=2).
module tb_core_pipe_exec_mdu_px;
  localparam int MUL = 0, MULH = 1, MULHU = 2, MULHSU = 3, DIV = 4, DIVU = 5, REM = 6, REMU = 7;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        g_clk = 1'b0;
  logic        g_reset, g_clk_req, flush, valid, op_word;
  logic        op_mul, op_mulh, op_mulhu, op_mulhsu, op_div, op_divu, op_rem, op_remu;
  logic [63:0] rs1, rs2, rd;
  logic        ready;

  core_pipe_exec_mdu_px #(.XLEN(64), .MUL_UNROLL(4), .DIV_UNROLL(2)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req), .flush(flush), .valid(valid),
    .op_word(op_word), .op_mul(op_mul), .op_mulh(op_mulh), .op_mulhu(op_mulhu),
    .op_mulhsu(op_mulhsu), .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem),
    .op_remu(op_remu), .rs1(rs1), .rs2(rs2), .ready(ready), .rd(rd)
  );

  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  int total = 0, bad = 0, n_ready = 0;
  logic [63:0] q_rd[$];
  int          q_cyc[$];
  string       q_name[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every ready pulse is matched against the oldest expected entry
  initial begin
    forever begin
      @(negedge g_clk);
      if (!g_reset && ready) begin
        n_ready++;
        if (q_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got rd=%0h at cycle %0d expected no pulse", rd, cyc);
        end else begin
          string nm;
          logic [63:0] e;
          int ec;
          nm = q_name.pop_front();
          e  = q_rd.pop_front();
          ec = q_cyc.pop_front();
          chk({nm, "_rd"}, rd, e);
          chk({nm, "_lat"}, 64'(cyc), 64'(ec));
        end
      end
    end
  end

  task automatic set_op(input int op, input logic w);
    op_mul    = (op == MUL);
    op_mulh   = (op == MULH);
    op_mulhu  = (op == MULHU);
    op_mulhsu = (op == MULHSU);
    op_div    = (op == DIV);
    op_divu   = (op == DIVU);
    op_rem    = (op == REM);
    op_remu   = (op == REMU);
    op_word   = w;
  endtask

  task automatic issue(input string name, input int op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] e, input int lat);
    int k;
    set_op(op, w);
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    q_name.push_back(name);
    q_rd.push_back(e);
    q_cyc.push_back(cyc + lat);
    k = 0;
    do begin
      @(negedge g_clk);
      k++;
    end while (!ready && k < 200);
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready in %0d cycles expected ready at +%0d", name, k, lat);
      void'(q_name.pop_front());
      void'(q_rd.pop_front());
      void'(q_cyc.pop_front());
    end
    valid = 1'b0;
    set_op(-1, 1'b0);
    @(negedge g_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    int c0, nr;
    g_reset = 1'b1;
    flush   = 1'b0;
    valid   = 1'b0;
    rs1     = '0;
    rs2     = '0;
    set_op(-1, 1'b0);
    repeat (3) @(negedge g_clk);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_rd", rd, 64'd0);
    chk("reset_clk_req", 64'(g_clk_req), 64'd0);
    valid = 1'b1;
    #1 chk("reset_clk_req_valid", 64'(g_clk_req), 64'd1);
    valid = 1'b0;
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("idle_clk_req", 64'(g_clk_req), 64'd0);

    issue("mul_7x6",      MUL,    1'b0, 64'd7, 64'd6, 64'h2A, 19);
    issue("mulh_m1x2",    MULH,   1'b0, ONES, 64'd2, ONES, 19);
    issue("mulhu_m1x2",   MULHU,  1'b0, ONES, 64'd2, 64'd1, 19);
    issue("mulhsu_m1x2",  MULHSU, 1'b0, ONES, 64'd2, ONES, 19);
    issue("mulhu_max",    MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 19);
    issue("mulw_wrap",    MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 11);
    issue("div_m7_2",     DIV,    1'b0, -64'sd7, 64'd2, -64'sd3, 35);
    issue("rem_m7_2",     REM,    1'b0, -64'sd7, 64'd2, ONES, 35);
    issue("divw_m7_2",    DIV,    1'b1, -64'sd7, 64'd2, -64'sd3, 19);
    issue("divu_big",     DIVU,   1'b0, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 35);
    issue("divu_by0",     DIVU,   1'b0, 64'd123, 64'd0, ONES, 2);
    issue("div_ovf",      DIV,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 2);
    issue("rem_by0",      REM,    1'b0, 64'h55, 64'd0, 64'h55, 2);
    issue("rem_ovf",      REM,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 2);
    issue("remw_by0",     REM,    1'b1, 64'h1_2345_6789, 64'd0, 64'h2345_6789, 2);
    issue("divw_ovf",     DIV,    1'b1, 64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 2);

    // flush during the fifth RUN cycle of a divide
    set_op(DIV, 1'b0);
    rs1   = 64'd100;
    rs2   = 64'd7;
    valid = 1'b1;
    c0    = cyc;
    repeat (6) @(negedge g_clk);
    flush = 1'b1;
    valid = 1'b0;
    set_op(-1, 1'b0);
    #1 chk("flush_clk_req", 64'(g_clk_req), 64'd1);
    nr = n_ready;
    @(negedge g_clk);
    flush = 1'b0;
    #1 chk("post_flush_clk_req", 64'(g_clk_req), 64'd0);
    chk("post_flush_ready", 64'(ready), 64'd0);
    chk("post_flush_rd", rd, 64'd0);
    repeat (45) @(negedge g_clk);
    chk("flush_no_ready", 64'(n_ready), 64'(nr));
    chk("flush_cycle", 64'(cyc), 64'(c0 + 52));
    issue("remu_10_3",    REMU,   1'b0, 64'd10, 64'd3, 64'd1, 35);

    issue("mulh_3x5",     MULH,   1'b0, 64'd3, 64'd5, 64'd0, 19);
`ifdef MDU_RESULT_FUSE_EN
    issue("mul_3x5_fuse", MUL,    1'b0, 64'd3, 64'd5, 64'd15, 1);
`else
    issue("mul_3x5_fuse", MUL,    1'b0, 64'd3, 64'd5, 64'd15, 19);
`endif
    issue("div_9_3",      DIV,    1'b0, 64'd9, 64'd3, 64'd3, 35);
    issue("mul_3x5_full", MUL,    1'b0, 64'd3, 64'd5, 64'd15, 19);

    repeat (5) @(negedge g_clk);
    chk("queue_drained", 64'(q_rd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
